spi_xfer_seq: RTL and testbench

//  Byte-transfer sequencer that sits directly upstream of the spi shift engine.
//  - Buffers outgoing bytes from the host in a TX FIFO and drives the engine's load/datain/unload pins.
//  - Captures each received byte into an RX FIFO.
//  - Host side uses valid/ready streams, so multi-byte bursts need no per-byte software timing.

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_byte_fifo.sv | 60 ++++++
 rtl/spi_xfer_seq.sv | 121 ++++++++++++
 tb/tb_spi_xfer_seq.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI byte-transfer sequencer.
// Holds the sequencer state enum, byte width and default sizing.
package spi_pkg;

    localparam int BYTE_W          = 8;
    localparam int DEF_DEPTH       = 4;
    localparam int DEF_BYTE_CYCLES = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        UNLOAD
    } state_t;

endpackage

// File: rtl/spi_byte_fifo.sv
// Synchronous DEPTH x 8 byte FIFO with full/empty flags and occupancy count.
// Ports: clock_in, reset (async, active-high), push/push_data, pop, head, full, empty, count.
module spi_byte_fifo
    import spi_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clock_in,
    input  logic                     reset,
    input  logic                     push,
    input  logic [BYTE_W-1:0]        push_data,
    input  logic                     pop,
    output logic [BYTE_W-1:0]        head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    // A push into a full FIFO is accepted only when a pop frees a slot on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spi_xfer_seq.sv
// Byte-transfer sequencer feeding the SPI shift engine from a TX FIFO into an RX FIFO.
// Ports: host tx/rx valid-ready streams, busy, engine load/datain/unload/dataout.
module spi_xfer_seq
    import spi_pkg::*;
#(
    parameter int DEPTH       = DEF_DEPTH,
    parameter int BYTE_CYCLES = DEF_BYTE_CYCLES
) (
    input  logic              clock_in,
    input  logic              reset,
    input  logic [BYTE_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              busy,
    output logic              spi_load,
    output logic [BYTE_W-1:0] spi_datain,
    output logic              spi_unload,
    input  logic [BYTE_W-1:0] spi_dataout
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t            state;
    logic [3:0]        shift_cnt;

    logic [BYTE_W-1:0] tx_head;
    logic              tx_full;
    logic              tx_empty;
    logic [CW-1:0]     tx_count;
    logic              rx_full;
    logic              rx_empty;
    logic [CW-1:0]     rx_count;

    logic              start_idle;
    logic              start_next;

    assign tx_ready = !tx_full;
    assign rx_valid = !rx_empty;
    assign busy     = (state != IDLE) || !tx_empty;

    // RX space is reserved before a byte is loaded, so the RX FIFO cannot overflow.
    // Leaving UNLOAD, the byte being pushed on that edge still occupies a slot.
    assign start_idle = !tx_empty && (rx_count < CW'(DEPTH));
    assign start_next = !tx_empty && (rx_count < CW'(DEPTH - 1));

    wire unused_ok = ^{tx_count, rx_full};

    spi_byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clock_in  (clock_in),
        .reset     (reset),
        .push      (tx_valid && tx_ready),
        .push_data (tx_data),
        .pop       (state == LOAD),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    spi_byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clock_in  (clock_in),
        .reset     (reset),
        .push      (state == UNLOAD),
        .push_data (spi_dataout),
        .pop       (rx_valid && rx_ready),
        .head      (rx_data),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    // load/unload/datain are registered alongside the state they decode.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shift_cnt  <= '0;
            spi_load   <= 1'b0;
            spi_unload <= 1'b0;
            spi_datain <= '0;
        end else begin
            spi_load   <= 1'b0;
            spi_unload <= 1'b0;
            spi_datain <= '0;
            unique case (state)
                IDLE: begin
                    if (start_idle) begin
                        state      <= LOAD;
                        spi_load   <= 1'b1;
                        spi_datain <= tx_head;
                    end
                end
                LOAD: begin
                    state     <= SHIFT;
                    shift_cnt <= 4'd1;
                end
                SHIFT: begin
                    if (shift_cnt == 4'(BYTE_CYCLES)) begin
                        state      <= UNLOAD;
                        spi_unload <= 1'b1;
                    end else begin
                        shift_cnt <= shift_cnt + 4'd1;
                    end
                end
                UNLOAD: begin
                    if (start_next) begin
                        state      <= LOAD;
                        spi_load   <= 1'b1;
                        spi_datain <= tx_head;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xfer_seq.sv
// Testbench for spi_xfer_seq with a loopback shift engine.
// Transaction-level queue model checked every cycle plus directed literal checks.
module tb_spi_xfer_seq;

    localparam int DEPTH = 4;

    logic       clock_in;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       busy;
    logic       spi_load;
    logic [7:0] spi_datain;
    logic       spi_unload;
    logic [7:0] spi_dataout;

    spi_xfer_seq #(.DEPTH(DEPTH), .BYTE_CYCLES(8)) dut (
        .clock_in    (clock_in),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .busy        (busy),
        .spi_load    (spi_load),
        .spi_datain  (spi_datain),
        .spi_unload  (spi_unload),
        .spi_dataout (spi_dataout)
    );

    // Loopback engine: captures on load, rotates one bit per clock,
    // so after 8 shifts the loaded byte is back in place.
    logic [7:0] eng_sr;
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) eng_sr <= '0;
        else if (spi_load) eng_sr <= spi_datain;
        else eng_sr <= {eng_sr[6:0], eng_sr[7]};
    end
    assign spi_dataout = eng_sr;

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Model: t = 0 idle, 1 load cycle, 2..9 shift, 10 unload.
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic [7:0] cur;
    int         t;

    int         load_cnt;
    int         unload_cnt;
    int         load_at[$];
    int         unload_at[$];
    logic [7:0] got[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        load_cnt   = 0;
        unload_cnt = 0;
        load_at.delete();
        unload_at.delete();
        got.delete();
    endtask

    task automatic check_all();
        chk("tx_ready", tx_ready, txq.size() < DEPTH);
        chk("rx_valid", rx_valid, rxq.size() > 0);
        chk("busy", busy, (t != 0) || (txq.size() > 0));
        chk("spi_load", spi_load, t == 1);
        chk("spi_unload", spi_unload, t == 10);
        chk("spi_datain", spi_datain, (t == 1) ? cur : 8'h00);
        if (rxq.size() > 0) chk("rx_data", rx_data, rxq[0]);
        if (spi_load) begin
            load_cnt++;
            load_at.push_back(cyc);
        end
        if (spi_unload) begin
            unload_cnt++;
            unload_at.push_back(cyc);
        end
        if (rx_valid && rx_ready) got.push_back(rx_data);
    endtask

    task automatic model_update();
        bit push;
        bit pop;
        bit txne;
        int rxn;
        int nt;
        push = tx_valid && (txq.size() < DEPTH);
        pop  = rx_ready && (rxq.size() > 0);
        txne = txq.size() > 0;
        rxn  = rxq.size();
        nt   = 0;
        if (t == 0) begin
            if (txne && rxn < DEPTH) begin
                nt  = 1;
                cur = txq[0];
            end
        end else if (t < 10) begin
            nt = t + 1;
            if (t == 1) void'(txq.pop_front());
        end
        if (pop) void'(rxq.pop_front());
        if (t == 10) begin
            rxq.push_back(cur);
            if (txne && rxn + 1 < DEPTH) begin
                nt  = 1;
                cur = txq[0];
            end
        end
        if (push) txq.push_back(tx_data);
        t = nt;
    endtask

    task automatic cycle();
        check_all();
        @(posedge clock_in);
        if (!reset) model_update();
        cyc++;
        @(negedge clock_in);
    endtask

    task automatic chk_seq(string name, logic [7:0] exp[$]);
        chk({name, " count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            chk({name, " byte"}, got[i], exp[i]);
        end
    endtask

    task automatic push_all(string name, logic [7:0] bytes[$]);
        int idx = 0;
        int g = 0;
        bit acc;
        while (idx < bytes.size() && g < 200) begin
            tx_data  = bytes[idx];
            tx_valid = 1'b1;
            acc      = tx_ready;
            cycle();
            if (acc) idx++;
            g++;
        end
        tx_valid = 1'b0;
        chk({name, " pushed"}, idx, bytes.size());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] b2[$];
        logic [7:0] b3[$];
        logic [7:0] b5[$];
        int g;
        int gap;

        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        rx_ready = 1'b0;
        t        = 0;
        cur      = 8'h00;
        clear_logs();

        @(negedge clock_in);
        @(negedge clock_in);
        check_all();
        chk("reset rx_data", rx_data, 8'h00);
        chk("reset tx_ready", tx_ready, 1'b1);
        reset = 1'b0;

        // 1: single byte
        clear_logs();
        push_all("t1", '{8'hA5});
        repeat (14) cycle();
        chk("t1 loads", load_cnt, 1);
        chk("t1 unloads", unload_cnt, 1);
        gap = (load_at.size() > 0 && unload_at.size() > 0) ?
              unload_at[0] - load_at[0] : -1;
        chk("t1 gap", gap, 9);
        chk("t1 rx_valid", rx_valid, 1'b1);
        chk("t1 rx_data", rx_data, 8'hA5);
        rx_ready = 1'b1;
        cycle();
        rx_ready = 1'b0;
        chk_seq("t1 rx", '{8'hA5});

        // 2: burst with rx_ready held high
        clear_logs();
        rx_ready = 1'b1;
        b2 = '{8'h01, 8'h80, 8'hFF, 8'h3C};
        push_all("t2", b2);
        repeat (50) cycle();
        chk("t2 loads", load_cnt, 4);
        for (int i = 1; i < load_at.size(); i++) begin
            chk("t2 load period", load_at[i] - load_at[i-1], 10);
        end
        chk_seq("t2 rx", b2);
        chk("t2 busy", busy, 1'b0);

        // 3: RX backpressure
        clear_logs();
        rx_ready = 1'b0;
        b3 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        push_all("t3", b3);
        repeat (60) cycle();
        chk("t3 held loads", load_cnt, 4);
        chk("t3 held busy", busy, 1'b1);
        chk("t3 held rx_valid", rx_valid, 1'b1);
        chk("t3 held tx_ready", tx_ready, 1'b1);
        rx_ready = 1'b1;
        repeat (40) cycle();
        chk("t3 loads", load_cnt, 6);
        chk_seq("t3 rx", b3);
        chk("t3 busy", busy, 1'b0);

        // 4: reset in the 4th shift cycle
        clear_logs();
        push_all("t4", '{8'hC3});
        g = 0;
        while (load_cnt == 0 && g < 10) begin
            cycle();
            g++;
        end
        chk("t4 load seen", load_cnt, 1);
        repeat (3) cycle();
        reset = 1'b1;
        #1;
        txq.delete();
        rxq.delete();
        t   = 0;
        cur = 8'h00;
        check_all();
        chk("t4 spi_load", spi_load, 1'b0);
        chk("t4 spi_unload", spi_unload, 1'b0);
        chk("t4 spi_datain", spi_datain, 8'h00);
        chk("t4 rx_data", rx_data, 8'h00);
        chk("t4 busy", busy, 1'b0);
        @(negedge clock_in);
        check_all();
        reset = 1'b0;
        clear_logs();
        push_all("t4b", '{8'h5A});
        repeat (20) cycle();
        chk_seq("t4 rx", '{8'h5A});

        // 5: host pop on the same edge as the UNLOAD push
        clear_logs();
        rx_ready = 1'b0;
        b5 = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        push_all("t5", b5);
        g = 0;
        while (unload_cnt < 4 && g < 80) begin
            rx_ready = spi_unload && (unload_cnt == 3);
            cycle();
            g++;
        end
        rx_ready = 1'b0;
        chk("t5 unloads", unload_cnt, 4);
        chk("t5 first pop", got.size(), 1);
        chk("t5 rx_valid", rx_valid, 1'b1);
        cycle();
        rx_ready = 1'b1;
        repeat (6) cycle();
        chk_seq("t5 rx", b5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
